mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single 64-bit, doubly-aligned physical memory port between the instruction-fetch requester (IFU, read-only) and the memory-stage load/store requester (LSU, read/write with byte mask).
- Sits between the IF/MEM pipeline stages and the pmem interface.
- Serialises one transaction at a time through a 3-state FSM.
- LSU has priority; a bounded anti-starvation counter guarantees fetch progress.

Parameters:
- MAX_LSU_STREAK, 4: consecutive LSU grants allowed while an IFU request is pending. Must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req_valid  in  1  IFU request
- if_req_ready  out  1  IFU request accepted
- if_addr  in  64  IFU byte address
- if_flush  in  1  fetch redirect; discard the pending IFU response
- if_resp_valid  out  1  IFU response pulse
- if_rdata  out  64  doubly-aligned read data to IFU
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted
- ls_addr  in  64  LSU byte address
- ls_wen  in  1  1 = write, 0 = read
- ls_wdata  in  64  write data, lane-aligned
- ls_wmask  in  8  byte write mask
- ls_resp_valid  out  1  LSU response / write-ack pulse
- ls_rdata  out  64  doubly-aligned read data to LSU
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  64  {addr[63:3],3'b0}
- mem_wen  out  1  write enable
- mem_wdata  out  64  write data
- mem_wmask  out  8  byte mask; forced to 0 on reads
- mem_resp_valid  in  1  memory read data / write ack
- mem_rdata  in  64  memory read data
- owner  out  1  0 = IFU, 1 = LSU; current or last grant

Behaviour:
- Reset (async): FSM=IDLE; all outputs 0; streak=0; drop=0. Assertion mid-transaction abandons it immediately; the memory side is reset by the same rst.
- FSM states: IDLE, ISSUE, WAIT.
- Arbitration, IDLE only, combinational on valids:
  - LSU wins if ls_req_valid, unless if_req_valid && streak==MAX_LSU_STREAK, in which case IFU wins.
  - Otherwise IFU wins if if_req_valid && !if_flush.
- Only the winner's req_ready is 1. Both readys are 0 outside IDLE. if_req_ready is gated by !if_flush.
- On handshake: capture addr, wen, wdata, wmask (IFU: wen=0, wmask=0) and owner into registers; IDLE→ISSUE.
- ISSUE:
  - mem_req_valid=1; mem_* driven from the captured registers and held stable until mem_req_ready.
  - On mem_req_ready: drop mem_req_valid next cycle; →WAIT.
- WAIT: on mem_resp_valid, capture mem_rdata into the owner's rdata register (reads and writes alike); →IDLE.
- Response timing:
  - Next cycle, the owner's resp_valid=1 for exactly one cycle.
  - The non-owner's rdata is unchanged.
  - Minimum latency: handshake at T, mem_req_valid at T+1, ready at T+1, resp at T+2, resp_valid at T+3.
  - A new request may be accepted in the same cycle resp_valid is high (FSM already IDLE).
- Streak counter:
  - LSU grant with if_req_valid=1: streak+1, saturating at MAX_LSU_STREAK.
  - LSU grant with if_req_valid=0: streak cleared.
  - Any IFU grant: streak cleared.
- Flush: if if_flush=1 while owner=IFU and FSM∈{ISSUE,WAIT}, or in the cycle FSM leaves WAIT, set drop. The transaction still completes on the memory side, but if_resp_valid is suppressed and if_rdata is not updated. drop clears on returning to IDLE.
- mem_resp_valid in IDLE/ISSUE and mem_req_ready outside ISSUE are ignored; the bench flags either as a protocol error.
- Address: mem_addr low 3 bits are always 0. Lane extraction is done by the requester.

Test Plan:
- IFU read, addr 0x8000_0004, mem ready immediately, resp 1 cycle later with rdata 0x1111_2222_3333_4444 → mem_addr 0x8000_0000, mem_wmask 0, if_resp_valid at T+3 for 1 cycle, if_rdata = 0x1111_2222_3333_4444, ls_resp_valid stays 0.
- LSU sd addr 0x8000_0010, wdata 0xDEAD_BEEF_0000_0001, wmask 0xFF, mem_req_ready delayed 3 cycles → mem_* stable for all 4 ISSUE cycles, single ls_resp_valid pulse after ack.
- IFU and LSU both valid continuously, MAX_LSU_STREAK=4 → grant order L,L,L,L,I,L,L,L,L,I; owner toggles accordingly.
- IFU read in WAIT, if_flush pulsed 1 cycle, mem_rdata=0xAAAA → no if_resp_valid, if_rdata keeps previous value, next IFU request accepted normally.
- rst asserted in WAIT with mem_resp_valid low → same-cycle (async) FSM=IDLE, mem_req_valid=0, all resp_valid=0, streak=0; first request after release behaves as from power-on.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IFU, LSU and physical-memory handshake signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory view.
interface mem_port_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_flush;
    logic        if_resp_valid;
    logic [63:0] if_rdata;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [63:0] ls_addr;
    logic        ls_wen;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic        ls_resp_valid;
    logic [63:0] ls_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        owner;

    modport slave (
        input  if_req_valid, if_addr, if_flush,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output if_req_ready, if_resp_valid, if_rdata,
        output ls_req_ready, ls_resp_valid, ls_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output owner
    );

    modport master (
        output if_req_valid, if_addr, if_flush,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  if_req_ready, if_resp_valid, if_rdata,
        input  ls_req_ready, ls_resp_valid, ls_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one doubly-aligned 64-bit memory port between instruction fetch and load/store,
// one transaction at a time; LSU has priority, a streak counter bounds fetch starvation.
module mem_port_arbiter #(
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int              SW         = (MAX_LSU_STREAK < 1) ? 1 : $clog2(MAX_LSU_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_LSU_STREAK);
    localparam logic [1:0]      ST_IDLE    = 2'd0;
    localparam logic [1:0]      ST_ISSUE   = 2'd1;
    localparam logic [1:0]      ST_WAIT    = 2'd2;

    logic [1:0]    state_q,    state_d;
    logic          owner_q,    owner_d;
    logic [60:0]   addr_q,     addr_d;
    logic          wen_q,      wen_d;
    logic [63:0]   wdata_q,    wdata_d;
    logic [7:0]    wmask_q,    wmask_d;
    logic          mreq_q,     mreq_d;
    logic [SW-1:0] streak_q,   streak_d;
    logic          drop_q,     drop_d;
    logic          if_resp_q,  if_resp_d;
    logic          ls_resp_q,  ls_resp_d;
    logic [63:0]   if_rdata_q, if_rdata_d;
    logic [63:0]   ls_rdata_q, ls_rdata_d;
    logic          ls_win_s;
    logic          if_win_s;
    logic          flush_hit_s;

    assign flush_hit_s = bus.if_flush && !owner_q;

    // Arbitration: LSU first unless the fetch side has waited out a full streak.
    always_comb begin
        ls_win_s = 1'b0;
        if_win_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.ls_req_valid && !(bus.if_req_valid && (streak_q == STREAK_MAX))) begin
                ls_win_s = 1'b1;
            end else if (bus.if_req_valid && !bus.if_flush) begin
                if_win_s = 1'b1;
            end else begin
                ls_win_s = 1'b0;
            end
        end else begin
            if_win_s = 1'b0;
        end
    end

    // Transaction sequencing, capture of the granted request and response routing.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        mreq_d     = mreq_q;
        streak_d   = streak_q;
        drop_d     = drop_q;
        if_resp_d  = 1'b0;
        ls_resp_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (ls_win_s) begin
                    state_d = ST_ISSUE;
                    mreq_d  = 1'b1;
                    owner_d = 1'b1;
                    addr_d  = bus.ls_addr[63:3];
                    wen_d   = bus.ls_wen;
                    wdata_d = bus.ls_wdata;
                    wmask_d = bus.ls_wen ? bus.ls_wmask : 8'h00;
                    if (!bus.if_req_valid) begin
                        streak_d = {SW{1'b0}};
                    end else if (streak_q == STREAK_MAX) begin
                        streak_d = streak_q;
                    end else begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (if_win_s) begin
                    state_d  = ST_ISSUE;
                    mreq_d   = 1'b1;
                    owner_d  = 1'b0;
                    addr_d   = bus.if_addr[63:3];
                    wen_d    = 1'b0;
                    wdata_d  = 64'd0;
                    wmask_d  = 8'h00;
                    streak_d = {SW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (flush_hit_s) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (bus.mem_req_ready) begin
                    state_d = ST_WAIT;
                    mreq_d  = 1'b0;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                    if (owner_q) begin
                        ls_resp_d  = 1'b1;
                        ls_rdata_d = bus.mem_rdata;
                    end else if (!(drop_q || flush_hit_s)) begin
                        if_resp_d  = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        if_resp_d = 1'b0;
                    end
                end else if (flush_hit_s) begin
                    drop_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mreq_d  = 1'b0;
                drop_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            addr_q     <= 61'd0;
            wen_q      <= 1'b0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'h00;
            mreq_q     <= 1'b0;
            streak_q   <= {SW{1'b0}};
            drop_q     <= 1'b0;
            if_resp_q  <= 1'b0;
            ls_resp_q  <= 1'b0;
            if_rdata_q <= 64'd0;
            ls_rdata_q <= 64'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            mreq_q     <= mreq_d;
            streak_q   <= streak_d;
            drop_q     <= drop_d;
            if_resp_q  <= if_resp_d;
            ls_resp_q  <= ls_resp_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.if_req_ready  = if_win_s;
    assign bus.ls_req_ready  = ls_win_s;
    assign bus.if_resp_valid = if_resp_q;
    assign bus.if_rdata      = if_rdata_q;
    assign bus.ls_resp_valid = ls_resp_q;
    assign bus.ls_rdata      = ls_rdata_q;
    assign bus.mem_req_valid = mreq_q;
    assign bus.mem_addr      = {addr_q, 3'b000};
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
    assign bus.owner         = owner_q;
endmodule
